// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue sequencer in front of the FP arithmetic unit.
// Takes one decoded FP instruction at a time, drives the FP unit with
// the latched op/operands, waits out the divider stall (with a timeout
// escape), and hands the result to FP register writeback over a
// valid/ready handshake. A flush aborts the instruction without writeback.
module fpu_issue_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 10
) (
    input  logic        in_Clk,
    input  logic        in_Rst_N,
    // Execute-stage instruction interface
    input  logic        in_valid,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    output logic        out_ready,
    input  logic        in_flush,
    // FP arithmetic unit interface
    output logic        out_fpu_start,
    output logic [1:0]  out_fpu_op,
    output logic [31:0] out_fpu_rs1,
    output logic [31:0] out_fpu_rs2,
    input  logic [31:0] in_fpu_data,
    input  logic        in_fpu_stall,
    // FP register writeback interface
    output logic        out_wb_valid,
    output logic [4:0]  out_wb_rd,
    output logic [31:0] out_wb_data,
    input  logic        in_wb_ready,
    output logic        out_timeout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXEC      = 3'd1,
        S_DIV_START = 3'd2,
        S_DIV_WAIT  = 3'd3,
        S_WB        = 3'd4,
        S_DRAIN     = 3'd5
    } state_e;

    localparam logic [1:0]       OP_DIV    = 2'b11;
    // Canonical quiet NaN written back when the divider never answers
    localparam logic [31:0]      QNAN      = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(DIV_TIMEOUT);

    state_e           state_q, state_d;
    logic [1:0]       op_q,    op_d;
    logic [31:0]      rs1_q,   rs1_d;
    logic [31:0]      rs2_q,   rs2_d;
    logic [4:0]       rd_q,    rd_d;
    logic [31:0]      wbdat_q, wbdat_d;
    logic             tmo_q,   tmo_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             start_c;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, latch and capture decisions; flush outranks every other event
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        wbdat_d = wbdat_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        start_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A flush in IDLE blocks acceptance even with in_valid high
                if (in_valid && !in_flush) begin
                    op_d    = in_op;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    rd_d    = in_rd;
                    state_d = (in_op == OP_DIV) ? S_DIV_START : S_EXEC;
                end
            end

            S_EXEC: begin
                // add/sub/mul are combinational in the FP unit: capture now
                if (in_flush) begin
                    state_d = S_IDLE;
                end else begin
                    wbdat_d = in_fpu_data;
                    state_d = S_WB;
                end
            end

            S_DIV_START: begin
                cnt_d = '0;
                if (in_flush) begin
                    state_d = S_IDLE;
                end else begin
                    start_c = 1'b1;
                    state_d = S_DIV_WAIT;
                end
            end

            S_DIV_WAIT: begin
                cnt_d = cnt_inc;
                if (in_flush) begin
                    // Divider is still running; let it finish before reuse
                    state_d = S_DRAIN;
                end else if (!in_fpu_stall) begin
                    // Real result wins even on the edge the limit is hit
                    wbdat_d = in_fpu_data;
                    state_d = S_WB;
                end else if (cnt_inc >= TMO_LIMIT) begin
                    wbdat_d = QNAN;
                    tmo_d   = 1'b1;
                    state_d = S_WB;
                end
            end

            S_WB: begin
                if (in_flush) begin
                    tmo_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (in_wb_ready) begin
                    // After a timeout the divider may still be busy
                    tmo_d   = 1'b0;
                    state_d = tmo_q ? S_DRAIN : S_IDLE;
                end
            end

            S_DRAIN: begin
                if (!in_fpu_stall) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand latches, result and counter registers
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wbdat_q <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            wbdat_q <= wbdat_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ready is forced low while reset is asserted so every output reads 0
    assign out_ready     = (state_q == S_IDLE) && !in_flush && in_Rst_N;
    assign out_fpu_start = start_c;
    assign out_fpu_op    = op_q;
    assign out_fpu_rs1   = rs1_q;
    assign out_fpu_rs2   = rs2_q;
    assign out_wb_valid  = (state_q == S_WB);
    assign out_wb_rd     = rd_q;
    assign out_wb_data   = wbdat_q;
    assign out_timeout   = tmo_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus random
// transactions, each checked against a transaction-timeline model.
module tb_fpu_issue_ctrl;

    localparam int          DT   = 8;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        in_Clk;
    logic        in_Rst_N;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_ready;
    logic        in_flush;
    logic        out_fpu_start;
    logic [1:0]  out_fpu_op;
    logic [31:0] out_fpu_rs1;
    logic [31:0] out_fpu_rs2;
    logic [31:0] in_fpu_data;
    logic        in_fpu_stall;
    logic        out_wb_valid;
    logic [4:0]  out_wb_rd;
    logic [31:0] out_wb_data;
    logic        in_wb_ready;
    logic        out_timeout;

    int n_chk = 0;
    int n_err = 0;

    // Last accepted instruction, which the operand outputs must keep showing
    logic [1:0]  last_op  = '0;
    logic [31:0] last_rs1 = '0;
    logic [31:0] last_rs2 = '0;

    fpu_issue_ctrl #(.DIV_TIMEOUT(DT), .CNT_W(10)) dut (
        .in_Clk        (in_Clk),
        .in_Rst_N      (in_Rst_N),
        .in_valid      (in_valid),
        .in_op         (in_op),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .out_ready     (out_ready),
        .in_flush      (in_flush),
        .out_fpu_start (out_fpu_start),
        .out_fpu_op    (out_fpu_op),
        .out_fpu_rs1   (out_fpu_rs1),
        .out_fpu_rs2   (out_fpu_rs2),
        .in_fpu_data   (in_fpu_data),
        .in_fpu_stall  (in_fpu_stall),
        .out_wb_valid  (out_wb_valid),
        .out_wb_rd     (out_wb_rd),
        .out_wb_data   (out_wb_data),
        .in_wb_ready   (in_wb_ready),
        .out_timeout   (out_timeout)
    );

    initial in_Clk = 1'b0;
    always #5 in_Clk = ~in_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // One instruction, accepted on the coming edge. The model predicts, in
    // cycles k after acceptance (k=1 is the first busy cycle):
    //   cap     - cycle whose FP-unit data becomes the result
    //   wb_*    - window where the result is offered to writeback
    //   k_idle  - first cycle the controller is ready again
    // S = number of divider-wait cycles the stub holds stall high,
    // bp = cycles of writeback backpressure, fk = cycle carrying a flush (0 none).
    task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] res,
                           input int S, input int bp, input int fk_in);
        bit is_div, tmo, started, in_wb;
        int cap, wb_first, wb_last, wb_hi, k_idle, fk;

        is_div   = (op == 2'b11);
        tmo      = is_div && (S >= DT);
        cap      = !is_div ? 1 : (tmo ? DT + 1 : S + 2);
        wb_first = cap + 1;
        wb_last  = wb_first + bp;
        fk       = (fk_in > wb_last) ? 0 : fk_in;
        started  = is_div && (fk != 1);
        wb_hi    = wb_last;

        if (fk == 0) begin
            k_idle = tmo ? imax(wb_last + 1, S + 2) + 1 : wb_last + 1;
        end else if (is_div && fk >= 2 && fk <= cap) begin
            // Flushed while the divider runs: drain until its stall drops
            k_idle = imax(fk + 1, S + 2) + 1;
            wb_hi  = 0;
        end else begin
            k_idle = fk + 1;
            wb_hi  = (fk < wb_first) ? 0 : fk;
        end

        in_valid     = 1'b1;
        in_op        = op;
        in_rs1       = a;
        in_rs2       = b;
        in_rd        = rd;
        in_flush     = 1'b0;
        in_fpu_stall = 1'b0;
        in_fpu_data  = $urandom;
        in_wb_ready  = 1'($urandom);
        #1;
        chk("accept_ready", 32'(out_ready), 32'd1);
        last_op  = op;
        last_rs1 = a;
        last_rs2 = b;

        for (int k = 1; k <= k_idle; k++) begin
            @(negedge in_Clk);
            in_flush     = (k == fk);
            in_valid     = (k < k_idle) ? 1'($urandom) : 1'b0;
            in_op        = 2'($urandom);
            in_rs1       = $urandom;
            in_rs2       = $urandom;
            in_rd        = 5'($urandom);
            in_fpu_data  = (k == cap) ? res : $urandom;
            in_fpu_stall = started && (k >= 2) && ((k - 1) <= S);
            in_wb_ready  = (k < wb_first) ? 1'($urandom) : (k >= wb_first + bp);
            #1;
            in_wb = (k >= wb_first) && (k <= wb_hi);
            chk("wb_valid",  32'(out_wb_valid),  32'(in_wb));
            chk("ready",     32'(out_ready),     32'(k == k_idle));
            chk("fpu_start", 32'(out_fpu_start), 32'(started && k == 1));
            chk("fpu_op",    32'(out_fpu_op),    32'(op));
            chk("fpu_rs1",   out_fpu_rs1,        a);
            chk("fpu_rs2",   out_fpu_rs2,        b);
            if (in_wb) begin
                chk("wb_rd",   32'(out_wb_rd),   32'(rd));
                chk("wb_data", out_wb_data,      tmo ? QNAN : res);
                chk("timeout", 32'(out_timeout), 32'(tmo));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_Rst_N     = 1'b1;
        in_valid     = 1'b0;
        in_op        = '0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_rd        = '0;
        in_flush     = 1'b0;
        in_fpu_data  = '0;
        in_fpu_stall = 1'b0;
        in_wb_ready  = 1'b0;
        #2 in_Rst_N = 1'b0;
        #1;
        chk("rst_ready",    32'(out_ready),     32'd0);
        chk("rst_wb_valid", 32'(out_wb_valid),  32'd0);
        chk("rst_start",    32'(out_fpu_start), 32'd0);
        chk("rst_op",       32'(out_fpu_op),    32'd0);
        chk("rst_rs1",      out_fpu_rs1,        32'd0);
        chk("rst_wb_data",  out_wb_data,        32'd0);
        chk("rst_timeout",  32'(out_timeout),   32'd0);
        @(negedge in_Clk);
        @(negedge in_Clk);
        in_Rst_N = 1'b1;
        #1;
        chk("rel_ready", 32'(out_ready), 32'd1);

        // Directed scenarios
        run_txn(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd5,  32'h4040_0000, 0,  0, 0); // add
        run_txn(2'b11, 32'h40C0_0000, 32'h4000_0000, 5'd7,  32'h4040_0000, 10, 0, 0); // div
        run_txn(2'b10, 32'h4020_0000, 32'h4080_0000, 5'd9,  32'h4120_0000, 0,  4, 0); // mul, backpressure
        run_txn(2'b11, 32'h3F80_0000, 32'h0000_0000, 5'd12, 32'h1234_5678, 14, 1, 0); // timeout + drain
        run_txn(2'b11, 32'h4100_0000, 32'h4000_0000, 5'd3,  32'h4080_0000, DT - 1, 0, 0); // just in time
        run_txn(2'b11, 32'h4100_0000, 32'h4000_0000, 5'd4,  32'h4080_0000, DT,     2, 0); // just too late
        run_txn(2'b11, 32'h40C0_0000, 32'h4000_0000, 5'd6,  32'h4040_0000, 10, 0, 4); // flush DIV_WAIT cyc 3
        run_txn(2'b11, 32'h40C0_0000, 32'h4000_0000, 5'd8,  32'h4040_0000, 5,  0, 1); // flush DIV_START
        run_txn(2'b01, 32'h4040_0000, 32'h3F80_0000, 5'd10, 32'h4000_0000, 0,  0, 1); // flush EXEC
        run_txn(2'b10, 32'h4040_0000, 32'h4040_0000, 5'd11, 32'h4110_0000, 0,  3, 3); // flush WB

        // Flush in IDLE together with in_valid: nothing may be latched
        in_valid = 1'b1;
        in_flush = 1'b1;
        in_op    = 2'b11;
        in_rs1   = 32'hDEAD_BEEF;
        in_rs2   = 32'hCAFE_F00D;
        #1;
        chk("idle_flush_ready", 32'(out_ready), 32'd0);
        @(negedge in_Clk);
        in_valid = 1'b0;
        in_flush = 1'b0;
        #1;
        chk("idle_flush_ready_after", 32'(out_ready),  32'd1);
        chk("idle_flush_op",          32'(out_fpu_op), 32'(last_op));
        chk("idle_flush_rs1",         out_fpu_rs1,     last_rs1);
        chk("idle_flush_rs2",         out_fpu_rs2,     last_rs2);

        // Random transactions
        for (int t = 0; t < 40; t++) begin
            int s, bp, fk;
            logic [1:0] op;
            op = 2'($urandom);
            s  = int'($urandom_range(0, 12));
            bp = int'($urandom_range(0, 3));
            fk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
            run_txn(op, $urandom, $urandom, 5'($urandom), $urandom, s, bp, fk);
        end

        // Asynchronous reset in the middle of a divide
        in_valid = 1'b1;
        in_op    = 2'b11;
        in_rs1   = 32'h4110_0000;
        in_rs2   = 32'h4040_0000;
        in_rd    = 5'd17;
        @(negedge in_Clk);
        in_valid = 1'b0;
        @(negedge in_Clk);
        in_fpu_stall = 1'b1;
        @(negedge in_Clk);
        #2 in_Rst_N = 1'b0;
        #1;
        chk("mid_rst_ready",    32'(out_ready),     32'd0);
        chk("mid_rst_wb_valid", 32'(out_wb_valid),  32'd0);
        chk("mid_rst_start",    32'(out_fpu_start), 32'd0);
        chk("mid_rst_op",       32'(out_fpu_op),    32'd0);
        chk("mid_rst_rs1",      out_fpu_rs1,        32'd0);
        chk("mid_rst_rs2",      out_fpu_rs2,        32'd0);
        chk("mid_rst_rd",       32'(out_wb_rd),     32'd0);
        chk("mid_rst_data",     out_wb_data,        32'd0);
        chk("mid_rst_timeout",  32'(out_timeout),   32'd0);
        @(negedge in_Clk);
        in_Rst_N     = 1'b1;
        in_fpu_stall = 1'b0;
        #1;
        chk("post_rst_ready", 32'(out_ready), 32'd1);
        run_txn(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'h4040_0000, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
